// File: rtl/obuft_shift_driver.sv
// -----------------------------------------------------------------------------
// obuft_shift_driver
//
// Parallel-to-serial driver feeding the I/T pins of a tri-state output buffer
// on a half-duplex single-wire pin. A word accepted over the READY/LOAD
// handshake is sent as one frame:
//   LEAD*DIV cycles of IDLE_LVL, WIDTH bits MSB-first (DIV cycles each),
//   TAIL*DIV cycles of IDLE_LVL.
// Outside a frame the pin is released (T=1) and I rests at IDLE_LVL.
//
// Handshake: a word is taken on any rising edge of C where READY=1 and
// LOAD=1. READY is high only while idle. LOAD seen while READY=0 is dropped:
// there is no queuing and no error flag. The cycle that carries the DONE
// pulse is itself idle, so a new LOAD there is accepted. This gives the
// minimum one-cycle high-Z turnaround between frames.
//
// Ports:
//   C     in   clock, rising edge
//   R     in   synchronous active-high reset; overrides LOAD
//   D     in   frame data, sampled at acceptance
//   LOAD  in   request to start a frame
//   READY out  idle, LOAD will be accepted
//   BUSY  out  frame in progress (pin driven)
//   DONE  out  one-cycle pulse on the first idle cycle after a frame
//   I     out  buffer data input
//   T     out  buffer tri-state control (1 = high-Z)
// -----------------------------------------------------------------------------
module obuft_shift_driver #(
  parameter int   WIDTH    = 8,
  parameter int   DIV      = 4,
  parameter int   LEAD     = 1,
  parameter int   TAIL     = 1,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             I,
  output logic             T
);

  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAXP0 = (WIDTH > LEAD) ? WIDTH : LEAD;
  localparam int MAXP  = (MAXP0 > TAIL) ? MAXP0 : TAIL;
  localparam int CW    = $clog2(MAXP + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [CW-1:0] LEAD_LAST  = CW'((LEAD > 0) ? LEAD - 1 : 0);
  localparam logic [CW-1:0] WIDTH_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'((TAIL > 0) ? TAIL - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_d;
  logic             period_end;
  logic             t_d;
  logic             i_d;

  // Last clock cycle of the current bit period.
  assign period_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        cnt_d = '0;
        if (LOAD) begin
          sr_d    = D;
          state_d = (LEAD > 0) ? ST_LEAD : ST_SHIFT;
        end
      end

      ST_LEAD: begin
        div_d = period_end ? '0 : div_q + DW'(1);
        if (period_end) begin
          if (cnt_q == LEAD_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_SHIFT: begin
        div_d = period_end ? '0 : div_q + DW'(1);
        if (period_end) begin
          sr_d = sr_q << 1;
          if (cnt_q == WIDTH_LAST) begin
            cnt_d = '0;
            if (TAIL > 0) begin
              state_d = ST_TAIL;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_TAIL: begin
        div_d = period_end ? '0 : div_q + DW'(1);
        if (period_end) begin
          if (cnt_q == TAIL_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pin outputs are derived from the next state so they can be flopped
    // alongside it. The pad never sees a combinational path from the inputs.
    t_d = (state_d == ST_IDLE);
    i_d = (state_d == ST_SHIFT) ? sr_d[WIDTH-1] : IDLE_LVL;
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      T       <= 1'b1;
      I       <= IDLE_LVL;
      READY   <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      T       <= t_d;
      I       <= i_d;
      READY   <= t_d;
      BUSY    <= ~t_d;
      DONE    <= done_d;
    end
  end

endmodule

// File: tb/tb_obuft_shift_driver.sv
// -----------------------------------------------------------------------------
// Bench for obuft_shift_driver. Two instances share the inputs:
//   dut_a: WIDTH=8, DIV=2, LEAD=1, TAIL=1, IDLE_LVL=1
//   dut_b: WIDTH=8, DIV=1, LEAD=0, TAIL=0, IDLE_LVL=1
// Each instance has a reference model. The model stores the cycle position
// inside the current frame, and the expected pin/handshake vector is worked
// out from that position with plain arithmetic.
// Vectors are packed {T, I, READY, BUSY, DONE}.
// -----------------------------------------------------------------------------
module tb_obuft_shift_driver;

  localparam int A_DIV = 2, A_LEAD = 1, A_TAIL = 1;
  localparam int B_DIV = 1, B_LEAD = 0, B_TAIL = 0;
  localparam int A_FLEN = (A_LEAD + 8 + A_TAIL) * A_DIV;
  localparam int B_FLEN = (B_LEAD + 8 + B_TAIL) * B_DIV;

  // clock / reset ------------------------------------------------------------
  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] D = 8'h00;

  always #5 C = ~C;

  logic ready_a, busy_a, done_a, i_a, t_a;
  logic ready_b, busy_b, done_b, i_b, t_b;

  obuft_shift_driver #(.WIDTH(8), .DIV(A_DIV), .LEAD(A_LEAD), .TAIL(A_TAIL), .IDLE_LVL(1'b1)) dut_a (
    .C(C), .R(R), .D(D), .LOAD(LOAD),
    .READY(ready_a), .BUSY(busy_a), .DONE(done_a), .I(i_a), .T(t_a)
  );

  obuft_shift_driver #(.WIDTH(8), .DIV(B_DIV), .LEAD(B_LEAD), .TAIL(B_TAIL), .IDLE_LVL(1'b1)) dut_b (
    .C(C), .R(R), .D(D), .LOAD(LOAD),
    .READY(ready_b), .BUSY(busy_b), .DONE(done_b), .I(i_b), .T(t_b)
  );

  int checks = 0;
  int errors = 0;

  // reference model ----------------------------------------------------------
  // pos = 0: idle. pos = 1..flen: driven cycle of the frame.
  // pos = flen+1: the DONE cycle, which is also idle.
  int         pos_a = 0, pos_b = 0;
  logic [7:0] word_a = 8'h00, word_b = 8'h00;
  logic [4:0] exp_a, exp_b, obs_a, obs_b;

  function automatic logic [4:0] exp_vec(int pos, logic [7:0] word, int div, int lead, int tail);
    int   flen;
    int   idx;
    logic b;
    flen = (lead + 8 + tail) * div;
    if (pos == 0) return 5'b11100;
    if (pos == flen + 1) return 5'b11101;
    idx = (pos - 1) / div;
    if (idx < lead || idx >= lead + 8) b = 1'b1;
    else b = word[7 - (idx - lead)];
    return {1'b0, b, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic adv(input logic r, input logic ld, input logic [7:0] d, input int flen,
                     inout int pos, inout logic [7:0] word);
    if (r) pos = 0;
    else if (pos == 0 || pos == flen + 1) begin
      if (ld) begin
        word = d;
        pos  = 1;
      end else begin
        pos = 0;
      end
    end else pos++;
  endtask

  // driver: one clock cycle. Inputs change on the falling edge. The models
  // advance on the rising edge, and outputs are sampled 1 time unit later.
  task automatic step(input logic r, input logic ld, input logic [7:0] d);
    @(negedge C);
    R = r; LOAD = ld; D = d;
    @(posedge C);
    adv(r, ld, d, A_FLEN, pos_a, word_a);
    adv(r, ld, d, B_FLEN, pos_b, word_b);
    exp_a = exp_vec(pos_a, word_a, A_DIV, A_LEAD, A_TAIL);
    exp_b = exp_vec(pos_b, word_b, B_DIV, B_LEAD, B_TAIL);
    #1;
    obs_a = {t_a, i_a, ready_a, busy_a, done_a};
    obs_b = {t_b, i_b, ready_b, busy_b, done_b};
  endtask

  // tests --------------------------------------------------------------------
  task automatic test_reset;
    step(1'b1, 1'b1, 8'h55);  // reset and LOAD together: reset wins
    checks++;
    if (obs_a !== 5'b11100) begin errors++; $display("FAIL reset_a: got %b expected %b", obs_a, 5'b11100); end
    checks++;
    if (obs_b !== 5'b11100) begin errors++; $display("FAIL reset_b: got %b expected %b", obs_b, 5'b11100); end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_a !== 5'b11100) begin errors++; $display("FAIL idle_a cycle %0d: got %b expected %b", j, obs_a, 5'b11100); end
      checks++;
      if (obs_b !== 5'b11100) begin errors++; $display("FAIL idle_b cycle %0d: got %b expected %b", j, obs_b, 5'b11100); end
    end
  endtask

  task automatic test_single_frame;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 24; j++) begin
      step(1'b0, (j == 0), (j == 0) ? 8'hA5 : 8'h00);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL frame_a5_a cycle %0d: got %b expected %b", j + 1, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL frame_a5_b cycle %0d: got %b expected %b", j + 1, obs_b, exp_b); end
      if (j == 20) begin
        checks++;
        if ({t_a, done_a} !== 2'b11) begin errors++; $display("FAIL frame_a5_done cycle 21: got T,DONE=%b expected 11", {t_a, done_a}); end
      end
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 48; j++) begin
      step(1'b0, (j < 42), (j == 0) ? 8'h00 : 8'hFF);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL b2b_a cycle %0d: got %b expected %b", j + 1, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL b2b_b cycle %0d: got %b expected %b", j + 1, obs_b, exp_b); end
      if (j == 20 || j == 21) begin
        checks++;
        if (t_a !== (j == 20)) begin errors++; $display("FAIL b2b_gap cycle %0d: got T=%b expected %b", j + 1, t_a, (j == 20)); end
      end
    end
  endtask

  task automatic test_load_ignored;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 23; j++) begin
      step(1'b0, (j == 0 || j == 8), (j == 8) ? 8'h3C : 8'hA5);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL load_busy_a cycle %0d: got %b expected %b", j + 1, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL load_busy_b cycle %0d: got %b expected %b", j + 1, obs_b, exp_b); end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 30; j++) begin
      step((j == 10), (j == 0), 8'hA5);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL rst_mid_a cycle %0d: got %b expected %b", j + 1, obs_a, exp_a); end
      if (j >= 10) begin
        checks++;
        if (obs_a !== 5'b11100) begin errors++; $display("FAIL rst_mid_idle cycle %0d: got %b expected %b", j + 1, obs_a, 5'b11100); end
      end
    end
  endtask

  task automatic test_div1;
    logic [7:0] pat;
    pat = 8'h81;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 12; j++) begin
      step(1'b0, (j == 0), 8'h81);
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL div1_b cycle %0d: got %b expected %b", j + 1, obs_b, exp_b); end
      if (j < 8) begin
        checks++;
        if ({t_b, i_b} !== {1'b0, pat[7 - j]}) begin errors++; $display("FAIL div1_bit cycle %0d: got T,I=%b expected %b", j + 1, {t_b, i_b}, {1'b0, pat[7 - j]}); end
      end
      if (j == 8) begin
        checks++;
        if ({t_b, done_b} !== 2'b11) begin errors++; $display("FAIL div1_done cycle 9: got T,DONE=%b expected 11", {t_b, done_b}); end
      end
    end
  endtask

  task automatic test_random;
    logic       r, ld;
    logic [7:0] d;
    step(1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 600; j++) begin
      r  = ($urandom_range(0, 59) == 0);
      ld = ($urandom_range(0, 3) == 0);
      d  = 8'($urandom);
      step(r, ld, d);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL random_a step %0d: got %b expected %b", j, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL random_b step %0d: got %b expected %b", j, obs_b, exp_b); end
    end
  endtask

  // sequence + report ----------------------------------------------------------
  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_load_ignored;
    test_reset_mid;
    test_div1;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obuft_shift_driver.md
# obuft_shift_driver

Parallel-to-serial driver that generates the data (`I`) and tri-state control (`T`) inputs for a tri-state output buffer on a half-duplex single-wire pin. It accepts a word over a ready/load handshake and drives a framed transmission: lead-in idle level, `WIDTH` data bits MSB-first, then trailing idle level. Between frames it releases the pin (`T`=1, high-Z). It sits directly upstream of the pad buffer; `I` and `T` connect straight to the buffer's `I` and `T` pins.

## Interface
- `WIDTH`, 8: data bits per frame, ≥1.
- `DIV`, 4: clock cycles per bit period, ≥1.
- `LEAD`, 1: bit periods of idle level driven before data, ≥0.
- `TAIL`, 1: bit periods of idle level driven after data, ≥0.
- `IDLE_LVL`, 1'b1: level driven on `I` during lead/tail and while released.

Ports:
- `C`  in  1  clock; all logic on its rising edge.
- `R`  in  1  reset; synchronous, active-high.
- `D`  in  WIDTH  frame data; sampled when `LOAD` and `READY` are both 1.
- `LOAD`  in  1  request to start a frame.
- `READY`  out  1  block can accept `LOAD` this cycle.
- `BUSY`  out  1  frame in progress (pin driven).
- `DONE`  out  1  one-cycle pulse when a frame completes.
- `I`  out  1  buffer data input.
- `T`  out  1  buffer tri-state control; 1 = high-Z, 0 = drive.

## Operation
- States: IDLE, LEAD, SHIFT, TAIL.
- All outputs are registered; no combinational path from inputs to `I`/`T`.
- Reset (`R`=1 at an edge) sets state to IDLE, `T`=1, `I`=`IDLE_LVL`, `READY`=1, `BUSY`=0, `DONE`=0, counters 0, and the shift register to 0.
- IDLE: `T`=1, `I`=`IDLE_LVL`, `READY`=1. When `LOAD`=1, capture `D` into the shift register and go to LEAD; if `LEAD`=0, go directly to SHIFT.
- LEAD: `T`=0, `I`=`IDLE_LVL` for `LEAD`×`DIV` cycles, then SHIFT.
- SHIFT: `T`=0, `I`=current MSB. Each bit is held for `DIV` cycles, then the register shifts left. After `WIDTH` bits go to TAIL, or to IDLE if `TAIL`=0.
- TAIL: `T`=0, `I`=`IDLE_LVL` for `TAIL`×`DIV` cycles, then IDLE.
- `BUSY` = (state ≠ IDLE). `READY` = (state = IDLE).
- `DONE` is 1 for exactly the first IDLE cycle after a completed frame.
- `LOAD` while not READY is ignored. No queuing and no error flag.
- Counters:
  - Divide counter: width clog2(`DIV`), minimum 1 bit; counts 0..`DIV`-1, wraps to 0.
  - Bit/period counter: width clog2(max(`WIDTH`,`LEAD`,`TAIL`)+1).
- `DIV`=1: one bit per cycle, no idle gaps inside a frame.

## Timing
- `LOAD` accepted at edge k: the first driven cycle (`T`=0) starts at k+1.
- Frame length with `T`=0: (`LEAD`+`WIDTH`+`TAIL`)×`DIV` cycles exactly.
- After the last driven cycle, `T`=1 and `DONE`=1 on the next cycle.
- Back-to-back: `LOAD` asserted during the `DONE` cycle is accepted. The pin is released (`T`=1) for exactly one cycle between frames. This is the guaranteed minimum bus-turnaround gap.
- `LOAD` held high continuously: frames repeat with a one-cycle high-Z gap; `D` is resampled at each acceptance.
- `R` mid-frame: the next cycle shows `T`=1, `I`=`IDLE_LVL`, `READY`=1, no `DONE`; the frame is discarded.
- `R` and `LOAD` in the same cycle: reset wins; `LOAD` is ignored.
- `D` changes after acceptance have no effect on the current frame.

## Test plan
All scenarios use `WIDTH`=8, `DIV`=2, `LEAD`=1, `TAIL`=1, `IDLE_LVL`=1 unless stated.
- Reset, then idle for 5 cycles → `T`=1, `I`=1, `READY`=1, `BUSY`=0, `DONE`=0 throughout.
- `LOAD` with `D`=8'hA5 at cycle 0 → `T`=0 on cycles 1–20:
  - `I`=1 on cycles 1–2 (lead).
  - Bits 1,0,1,0,0,1,0,1, each 2 cycles, on cycles 3–18.
  - `I`=1 on cycles 19–20 (tail).
  - Cycle 21: `T`=1, `DONE`=1.
- `LOAD` kept high with `D`=8'h00 then 8'hFF → second frame's `T`=0 begins at cycle 22 with exactly one `T`=1 cycle (21) between frames; data bits all 0, then all 1.
- `LOAD` pulsed during SHIFT at cycle 8 with `D`=8'h3C → ignored; the 8'hA5 frame completes unchanged.
- `R` asserted at cycle 10 of an 8'hA5 frame → cycle 11: `T`=1, `I`=1, `READY`=1, `BUSY`=0; no `DONE` pulse ever follows.
- `DIV`=1, `LEAD`=0, `TAIL`=0, `D`=8'h81 → `T`=0 on cycles 1–8, `I`=1,0,0,0,0,0,0,1; `DONE`=1 on cycle 9.
